dphy_rx_ctrl: RTL and testbench

- Receive-side sequencer for the D-PHY slave datapath, running in the byte-clock domain.
- Gates the slave's enable after RX clock presence plus a settle interval.
- Parses the CSI-2 packet header from the 32-bit mapped word stream and counts payload plus CRC words.
- Pulses the slave's phy-reset/EOP input at each packet end so byte/word alignment re-arms for the next SoT. Also recovers from truncated packets by timeout.

---
 rtl/dphy_rx_pkg.sv | 32 +++
 rtl/dphy_hdr_parse.sv | 23 ++
 rtl/dphy_rx_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dphy_rx_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dphy_rx_pkg.sv
// Shared types and helpers for the D-PHY receive-side sequencer.
package dphy_rx_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_WAIT_SOT = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_EOP      = 3'd4
  } state_e;

  // CSI-2 packet header as it arrives in the 32-bit mapped word (byte0 = di)
  typedef struct packed {
    logic [7:0]  ecc;
    logic [15:0] wc;
    logic [7:0]  di;
  } hdr_t;

  // Data types at or below this value carry no payload
  localparam logic [5:0] SHORT_DT_MAX = 6'h0F;

  // 32-bit words still to come after the header: payload bytes plus the
  // 2-byte CRC, rounded up to whole words. Done at 17 bits so WC=16'hFFFF
  // cannot wrap.
  function automatic logic [16:0] words_from_wc(input logic [15:0] wc);
    logic [16:0] total;
    total = {1'b0, wc} + 17'd5;
    return total >> 2;
  endfunction

endpackage

// File: rtl/dphy_hdr_parse.sv
// Combinational CSI-2 header field split and payload word-count derivation.
module dphy_hdr_parse
  import dphy_rx_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [7:0]  di_o,
  output logic [15:0] wc_o,
  output logic        is_short_o,
  output logic [16:0] words_o
);

  hdr_t hdr;
  // ECC is checked further downstream; it is deliberately dropped here.
  logic unused_ecc;

  assign hdr        = data_i;
  assign unused_ecc = ^hdr.ecc;
  assign di_o       = hdr.di;
  assign wc_o       = hdr.wc;
  assign is_short_o = (hdr.di[5:0] <= SHORT_DT_MAX);
  assign words_o    = words_from_wc(hdr.wc);

endmodule

// File: rtl/dphy_rx_ctrl.sv
// Receive-side sequencer for the D-PHY slave: gates enable after clock
// presence and settle, tracks CSI-2 packets and pulses phy_rst at each end.
module dphy_rx_ctrl
  import dphy_rx_pkg::*;
#(
  parameter int SETTLE_TICKS  = 16,
  parameter int EOP_TICKS     = 4,
  parameter int TIMEOUT_TICKS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        rx_clk_present_i,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  output logic        enable_o,
  output logic        phy_rst_o,
  output logic        pkt_start_o,
  output logic [7:0]  di_o,
  output logic [15:0] wc_o,
  output logic        pkt_active_o,
  output logic        timeout_o
);

  // One counter serves settle, EOP hold and payload idle timing; size it
  // for the largest of the three.
  localparam int CNT_MAX = (TIMEOUT_TICKS > SETTLE_TICKS)
                           ? ((TIMEOUT_TICKS > EOP_TICKS) ? TIMEOUT_TICKS : EOP_TICKS)
                           : ((SETTLE_TICKS > EOP_TICKS) ? SETTLE_TICKS : EOP_TICKS);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [16:0]       words_left_q, words_left_d;
  logic [7:0]        di_q, di_d;
  logic [15:0]       wc_q, wc_d;
  logic              enable_q, enable_d;
  logic              phy_rst_q, phy_rst_d;
  logic              pkt_start_q, pkt_start_d;
  logic              pkt_active_q, pkt_active_d;
  logic              timeout_q, timeout_d;

  logic [7:0]        hdr_di;
  logic [15:0]       hdr_wc;
  logic              hdr_short;
  logic [16:0]       hdr_words;

  dphy_hdr_parse u_hdr_parse (
    .data_i     (data_i),
    .di_o       (hdr_di),
    .wc_o       (hdr_wc),
    .is_short_o (hdr_short),
    .words_o    (hdr_words)
  );

  // Next-state, counter and output decode; outputs follow the next state so
  // they change on the same edge as the state register.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    words_left_d = words_left_q;
    di_d         = di_q;
    wc_d         = wc_q;
    pkt_start_d  = 1'b0;
    timeout_d    = 1'b0;

    if (!rx_clk_present_i) begin
      // Clock loss wins over everything; header fields are kept for debug.
      state_d      = ST_IDLE;
      cnt_d        = '0;
      words_left_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
        ST_SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_TICKS - 1)) begin
            state_d = ST_WAIT_SOT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_SOT: begin
          if (valid_i) begin
            di_d        = hdr_di;
            wc_d        = hdr_wc;
            pkt_start_d = 1'b1;
            cnt_d       = '0;
            if (hdr_short) begin
              state_d = ST_EOP;
            end else begin
              words_left_d = hdr_words;
              state_d      = ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          // A valid word always takes priority over the idle timeout.
          if (valid_i) begin
            cnt_d = '0;
            if (words_left_q == 17'd1) begin
              words_left_d = '0;
              state_d      = ST_EOP;
            end else begin
              words_left_d = words_left_q - 17'd1;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_EOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_EOP: begin
          if (cnt_q == CNT_W'(EOP_TICKS - 1)) begin
            state_d = ST_WAIT_SOT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    enable_d     = (state_d == ST_WAIT_SOT) || (state_d == ST_PAYLOAD) ||
                   (state_d == ST_EOP);
    phy_rst_d    = (state_d == ST_EOP);
    pkt_active_d = (state_d == ST_PAYLOAD);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      words_left_q <= '0;
      di_q         <= '0;
      wc_q         <= '0;
      enable_q     <= 1'b0;
      phy_rst_q    <= 1'b0;
      pkt_start_q  <= 1'b0;
      pkt_active_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      words_left_q <= words_left_d;
      di_q         <= di_d;
      wc_q         <= wc_d;
      enable_q     <= enable_d;
      phy_rst_q    <= phy_rst_d;
      pkt_start_q  <= pkt_start_d;
      pkt_active_q <= pkt_active_d;
      timeout_q    <= timeout_d;
    end
  end

  assign enable_o     = enable_q;
  assign phy_rst_o    = phy_rst_q;
  assign pkt_start_o  = pkt_start_q;
  assign di_o         = di_q;
  assign wc_o         = wc_q;
  assign pkt_active_o = pkt_active_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_dphy_rx_ctrl.sv
// Self-checking bench for dphy_rx_ctrl: randomized packets against a
// packet-level expectation of enable, EOP and timeout timing.
module tb_dphy_rx_ctrl;

  localparam int SETTLE  = 16;
  localparam int EOPT    = 4;
  localparam int TIMEOUT = 1024;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        rx_clk_present_i;
  logic [31:0] data_i;
  logic        valid_i;
  logic        enable_o;
  logic        phy_rst_o;
  logic        pkt_start_o;
  logic [7:0]  di_o;
  logic [15:0] wc_o;
  logic        pkt_active_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  dphy_rx_ctrl #(
    .SETTLE_TICKS  (SETTLE),
    .EOP_TICKS     (EOPT),
    .TIMEOUT_TICKS (TIMEOUT)
  ) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .rx_clk_present_i (rx_clk_present_i),
    .data_i           (data_i),
    .valid_i          (valid_i),
    .enable_o         (enable_o),
    .phy_rst_o        (phy_rst_o),
    .pkt_start_o      (pkt_start_o),
    .di_o             (di_o),
    .wc_o             (wc_o),
    .pkt_active_o     (pkt_active_o),
    .timeout_o        (timeout_o)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Reference rules, stated arithmetically
  function automatic int words_for(input logic [15:0] wc);
    return (int'(wc) + 5) / 4;
  endfunction

  function automatic bit is_short(input logic [7:0] di);
    return int'(di[5:0]) <= 15;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // After clock presence: one cycle to leave IDLE, then SETTLE cycles.
  task automatic run_settle(input string name);
    bit exp_en;
    for (int n = 1; n <= SETTLE + 3; n++) begin
      step();
      exp_en = (n >= SETTLE + 1);
      checks++;
      if (enable_o !== exp_en || phy_rst_o !== 1'b0 || pkt_active_o !== 1'b0 ||
          pkt_start_o !== 1'b0 || timeout_o !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle %0d: enable=%0b phy_rst=%0b active=%0b start=%0b timeout=%0b, expected enable=%0b and others 0",
                 name, n, enable_o, phy_rst_o, pkt_active_o, pkt_start_o, timeout_o, exp_en);
      end
    end
  endtask

  // Full packet: header, payload words with random gaps, EOP pulse.
  task automatic send_packet(input logic [7:0] di, input logic [15:0] wc, input int max_gap,
                             input bit hold_next, input logic [31:0] next_hdr, input string name);
    int n_words;
    bit shrt;
    bit exp_rst;
    bit exp_act;
    shrt    = is_short(di);
    n_words = shrt ? 0 : words_for(wc);
    data_i  = {8'($urandom), wc, di};
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    data_i  = $urandom;
    checks++;
    if (pkt_start_o !== 1'b1 || di_o !== di || wc_o !== wc) begin
      errors++;
      $display("FAIL %s hdr_accept: start=%0b di=%h wc=%h, expected start=1 di=%h wc=%h",
               name, pkt_start_o, di_o, wc_o, di, wc);
    end
    checks++;
    if (pkt_active_o !== !shrt || phy_rst_o !== shrt || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL %s hdr_state: active=%0b phy_rst=%0b timeout=%0b, expected active=%0b phy_rst=%0b timeout=0",
               name, pkt_active_o, phy_rst_o, timeout_o, !shrt, shrt);
    end
    for (int w = 1; w <= n_words; w++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        step();
        checks++;
        if (pkt_active_o !== 1'b1 || phy_rst_o !== 1'b0 || pkt_start_o !== 1'b0 || timeout_o !== 1'b0) begin
          errors++;
          $display("FAIL %s payload_gap word %0d: active=%0b phy_rst=%0b start=%0b timeout=%0b, expected 1 0 0 0",
                   name, w, pkt_active_o, phy_rst_o, pkt_start_o, timeout_o);
        end
      end
      data_i  = $urandom;
      valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      exp_rst = (w == n_words);
      exp_act = (w != n_words);
      checks++;
      if (pkt_active_o !== exp_act || phy_rst_o !== exp_rst || pkt_start_o !== 1'b0 || timeout_o !== 1'b0) begin
        errors++;
        $display("FAIL %s payload_word %0d of %0d: active=%0b phy_rst=%0b start=%0b timeout=%0b, expected active=%0b phy_rst=%0b start=0 timeout=0",
                 name, w, n_words, pkt_active_o, phy_rst_o, pkt_start_o, timeout_o, exp_act, exp_rst);
      end
    end
    // EOP: valid is ignored while phy_rst is held
    for (int e = 1; e <= EOPT; e++) begin
      if (hold_next) begin
        data_i  = next_hdr;
        valid_i = 1'b1;
      end else begin
        data_i  = $urandom;
        valid_i = 1'($urandom_range(1, 0));
      end
      step();
      exp_rst = (e < EOPT);
      checks++;
      if (phy_rst_o !== exp_rst || enable_o !== 1'b1 || pkt_start_o !== 1'b0 ||
          pkt_active_o !== 1'b0 || di_o !== di || wc_o !== wc) begin
        errors++;
        $display("FAIL %s eop cycle %0d: phy_rst=%0b enable=%0b start=%0b active=%0b di=%h wc=%h, expected phy_rst=%0b enable=1 start=0 active=0 di=%h wc=%h",
                 name, e, phy_rst_o, enable_o, pkt_start_o, pkt_active_o, di_o, wc_o, exp_rst, di, wc);
      end
    end
    if (!hold_next) valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i          = 1'b0;
    rx_clk_present_i = 1'b1;
    valid_i          = 1'b0;
    data_i           = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (enable_o !== 1'b0 || phy_rst_o !== 1'b0 || pkt_start_o !== 1'b0 || di_o !== 8'h00 ||
          wc_o !== 16'h0000 || pkt_active_o !== 1'b0 || timeout_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: enable=%0b phy_rst=%0b start=%0b di=%h wc=%h active=%0b timeout=%0b, expected all 0",
                 enable_o, phy_rst_o, pkt_start_o, di_o, wc_o, pkt_active_o, timeout_o);
      end
    end
    rst_n_i = 1'b1;
    run_settle("reset_settle");
  endtask

  task automatic test_long_packet();
    send_packet(8'h2B, 16'h0008, 0, 1'b0, 32'h0, "long_wc8");
  endtask

  task automatic test_short_packet();
    send_packet(8'h00, 16'h0001, 0, 1'b0, 32'h0, "short_fs");
    send_packet(8'hC1, 16'h1234, 0, 1'b0, 32'h0, "short_vc3_fe");
  endtask

  task automatic test_back_to_back();
    send_packet(8'h2B, 16'h0008, 2, 1'b1, {8'h11, 16'h0010, 8'h6B}, "b2b_first");
    send_packet(8'h6B, 16'h0010, 1, 1'b1, {8'h22, 16'h0002, 8'h02}, "b2b_second");
    send_packet(8'h02, 16'h0002, 0, 1'b0, 32'h0, "b2b_short");
  endtask

  task automatic test_dt_boundary();
    send_packet(8'h0F, 16'h0040, 0, 1'b0, 32'h0, "dt_0f_short");
    send_packet(8'h10, 16'h0004, 1, 1'b0, 32'h0, "dt_10_long");
  endtask

  task automatic test_wc_zero();
    send_packet(8'h2A, 16'h0000, 2, 1'b0, 32'h0, "wc_zero");
  endtask

  task automatic test_random_packets();
    logic [7:0]  di;
    logic [15:0] wc;
    for (int i = 0; i < 10; i++) begin
      di = 8'($urandom);
      wc = 16'($urandom_range(80, 0));
      send_packet(di, wc, 3, 1'b0, 32'h0, "random_pkt");
      for (int g = 0; g < int'($urandom_range(3, 0)); g++) begin
        step();
        checks++;
        if (enable_o !== 1'b1 || phy_rst_o !== 1'b0 || pkt_active_o !== 1'b0) begin
          errors++;
          $display("FAIL random_idle: enable=%0b phy_rst=%0b active=%0b, expected 1 0 0",
                   enable_o, phy_rst_o, pkt_active_o);
        end
      end
    end
  endtask

  task automatic test_truncation();
    int pulses;
    bit exp_to, exp_rst, exp_act;
    data_i  = {8'h99, 16'h0040, 8'h2B};
    valid_i = 1'b1;
    step();
    for (int w = 0; w < 5; w++) begin
      data_i = $urandom;
      step();
    end
    valid_i = 1'b0;
    pulses  = 0;
    for (int n = 1; n <= TIMEOUT + EOPT; n++) begin
      step();
      if (timeout_o === 1'b1) pulses++;
      exp_to  = (n == TIMEOUT);
      exp_rst = (n >= TIMEOUT) && (n < TIMEOUT + EOPT);
      exp_act = (n < TIMEOUT);
      checks++;
      if (timeout_o !== exp_to || phy_rst_o !== exp_rst || pkt_active_o !== exp_act) begin
        errors++;
        $display("FAIL truncation idle %0d: timeout=%0b phy_rst=%0b active=%0b, expected %0b %0b %0b",
                 n, timeout_o, phy_rst_o, pkt_active_o, exp_to, exp_rst, exp_act);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL truncation_pulse_count: got %0d timeout pulses, expected 1", pulses);
    end
  endtask

  task automatic test_timeout_edge();
    // WC=8 -> 3 words; words 2 and 3 land on the cycle the idle count would expire
    data_i  = {8'h00, 16'h0008, 8'h2B};
    valid_i = 1'b1;
    step();
    data_i = $urandom;
    step();
    valid_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int n = 1; n < TIMEOUT; n++) begin
        step();
        checks++;
        if (timeout_o !== 1'b0 || pkt_active_o !== 1'b1 || phy_rst_o !== 1'b0) begin
          errors++;
          $display("FAIL timeout_edge idle %0d/%0d: timeout=%0b active=%0b phy_rst=%0b, expected 0 1 0",
                   k, n, timeout_o, pkt_active_o, phy_rst_o);
        end
      end
      data_i  = $urandom;
      valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      checks++;
      if (timeout_o !== 1'b0 || pkt_active_o !== (k == 0) || phy_rst_o !== (k == 1)) begin
        errors++;
        $display("FAIL timeout_edge word %0d: timeout=%0b active=%0b phy_rst=%0b, expected timeout=0 active=%0b phy_rst=%0b",
                 k + 2, timeout_o, pkt_active_o, phy_rst_o, (k == 0), (k == 1));
      end
    end
    for (int e = 1; e <= EOPT; e++) begin
      step();
      checks++;
      if (phy_rst_o !== (e < EOPT) || timeout_o !== 1'b0) begin
        errors++;
        $display("FAIL timeout_edge eop %0d: phy_rst=%0b timeout=%0b, expected %0b 0",
                 e, phy_rst_o, timeout_o, (e < EOPT));
      end
    end
  endtask

  task automatic test_clock_loss();
    data_i  = {8'h5A, 16'h0100, 8'h2B};
    valid_i = 1'b1;
    step();
    for (int w = 0; w < 2; w++) begin
      data_i = $urandom;
      step();
    end
    valid_i = 1'b0;
    checks++;
    if (pkt_active_o !== 1'b1) begin
      errors++;
      $display("FAIL loss_pre: active=%0b, expected 1", pkt_active_o);
    end
    rx_clk_present_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (enable_o !== 1'b0 || pkt_active_o !== 1'b0 || phy_rst_o !== 1'b0 || timeout_o !== 1'b0 ||
          pkt_start_o !== 1'b0 || di_o !== 8'h2B || wc_o !== 16'h0100) begin
        errors++;
        $display("FAIL loss_payload cycle %0d: enable=%0b active=%0b phy_rst=%0b timeout=%0b start=%0b di=%h wc=%h, expected 0 0 0 0 0 di=2b wc=0100",
                 i, enable_o, pkt_active_o, phy_rst_o, timeout_o, pkt_start_o, di_o, wc_o);
      end
      data_i  = $urandom;
      valid_i = 1'($urandom_range(1, 0));
    end
    valid_i          = 1'b0;
    rx_clk_present_i = 1'b1;
    run_settle("loss_resettle");
    // Clock loss while the EOP pulse is active
    data_i  = {8'h00, 16'h0001, 8'h01};
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    checks++;
    if (phy_rst_o !== 1'b1) begin
      errors++;
      $display("FAIL loss_eop_pre: phy_rst=%0b, expected 1", phy_rst_o);
    end
    rx_clk_present_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (phy_rst_o !== 1'b0 || enable_o !== 1'b0 || di_o !== 8'h01 || wc_o !== 16'h0001) begin
        errors++;
        $display("FAIL loss_eop cycle %0d: phy_rst=%0b enable=%0b di=%h wc=%h, expected 0 0 di=01 wc=0001",
                 i, phy_rst_o, enable_o, di_o, wc_o);
      end
    end
    rx_clk_present_i = 1'b1;
    run_settle("loss_eop_resettle");
  endtask

  task automatic test_async_reset();
    data_i  = {8'h00, 16'h0020, 8'h6B};
    valid_i = 1'b1;
    step();
    data_i = $urandom;
    step();
    valid_i = 1'b0;
    #3;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (enable_o !== 1'b0 || pkt_active_o !== 1'b0 || di_o !== 8'h00 || wc_o !== 16'h0000 ||
        phy_rst_o !== 1'b0 || timeout_o !== 1'b0 || pkt_start_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: enable=%0b active=%0b di=%h wc=%h phy_rst=%0b timeout=%0b start=%0b, expected all 0",
               enable_o, pkt_active_o, di_o, wc_o, phy_rst_o, timeout_o, pkt_start_o);
    end
    step();
    step();
    rst_n_i = 1'b1;
    run_settle("async_reset_settle");
  endtask

  task automatic test_wc_max();
    send_packet(8'h2B, 16'hFFFF, 0, 1'b0, 32'h0, "wc_max");
  endtask

  initial begin
    test_reset();
    test_long_packet();
    test_short_packet();
    test_back_to_back();
    test_dt_boundary();
    test_wc_zero();
    test_random_packets();
    test_truncation();
    test_timeout_edge();
    test_clock_loss();
    test_async_reset();
    test_wc_max();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
